// File: rtl/bus_pkg.sv
// Shared constants for the 2-master / 3-slave system bus arbiter.
package bus_pkg;

    // Encodings driven onto the bus multiplexer's master select
    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_M1   = 2'd1;
    localparam logic [1:0] GRANT_M2   = 2'd2;

    // Slave ids as carried on mX_slave_id and slave_sel; 0 means no slave
    localparam logic [1:0] SLAVE_NONE = 2'd0;
    localparam logic [1:0] SLAVE_S1   = 2'd1;
    localparam logic [1:0] SLAVE_S2   = 2'd2;
    localparam logic [1:0] SLAVE_S3   = 2'd3;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GNT_M1 = 2'd1;
    localparam logic [1:0] ST_GNT_M2 = 2'd2;
    localparam logic [1:0] ST_TURN   = 2'd3;

    // A slave id of 0 can never be granted
    function automatic logic slave_id_valid(input logic [1:0] id);
        return id != SLAVE_NONE;
    endfunction

endpackage

// File: rtl/bus_arbiter_tenure_timer.sv
// Tenure length counter: cleared while no tenure runs, counts every cycle of a
// tenure and flags the last permitted cycle (count == TIMEOUT-1).
module tenure_timer #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear has priority so every tenure starts from zero
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == TC_VALUE);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with one turnaround cycle between tenures
// and a tenure timeout that locks out a master until it drops its request.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m1_request,
    input  logic [1:0] m1_slave_id,
    input  logic       m2_request,
    input  logic [1:0] m2_slave_id,
    output logic [1:0] bus_grant,
    output logic [1:0] slave_sel,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       m1_timeout,
    output logic       m2_timeout,
    output logic       bus_busy
);

    logic [1:0] state_d, state_q;
    logic [1:0] last_owner_d, last_owner_q;
    logic       m1_lock_d, m1_lock_q;
    logic       m2_lock_d, m2_lock_q;
    logic [1:0] bus_grant_d, bus_grant_q;
    logic [1:0] slave_sel_d, slave_sel_q;
    logic       m1_grant_d, m1_grant_q;
    logic       m2_grant_d, m2_grant_q;
    logic       m1_timeout_d, m1_timeout_q;
    logic       m2_timeout_d, m2_timeout_q;
    logic       bus_busy_d, bus_busy_q;

    logic m1_eligible;
    logic m2_eligible;
    logic tenure_stays;
    logic timer_terminal;

    assign m1_eligible = m1_request && slave_id_valid(m1_slave_id) && !m1_lock_q;
    assign m2_eligible = m2_request && slave_id_valid(m2_slave_id) && !m2_lock_q;

    // The timer only keeps counting while the same tenure continues
    assign tenure_stays = ((state_q == ST_GNT_M1) || (state_q == ST_GNT_M2))
                          && (state_d == state_q);

    tenure_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tenure_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!tenure_stays),
        .enable   (tenure_stays),
        .terminal (timer_terminal)
    );

    // FSM transitions, round-robin pick, timeout detection and lock bookkeeping
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        m1_lock_d    = m1_lock_q && m1_request;
        m2_lock_d    = m2_lock_q && m2_request;
        m1_timeout_d = 1'b0;
        m2_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m1_eligible && (!m2_eligible || last_owner_q == GRANT_M2)) begin
                    state_d      = ST_GNT_M1;
                    last_owner_d = GRANT_M1;
                end else if (m2_eligible) begin
                    state_d      = ST_GNT_M2;
                    last_owner_d = GRANT_M2;
                end
            end
            ST_GNT_M1: begin
                if (!m1_request) begin
                    state_d = ST_TURN;
                end else if (timer_terminal) begin
                    state_d      = ST_TURN;
                    m1_timeout_d = 1'b1;
                    m1_lock_d    = 1'b1;
                end
            end
            ST_GNT_M2: begin
                if (!m2_request) begin
                    state_d = ST_TURN;
                end else if (timer_terminal) begin
                    state_d      = ST_TURN;
                    m2_timeout_d = 1'b1;
                    m2_lock_d    = 1'b1;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered; slave_sel latches on tenure entry
    always_comb begin
        bus_grant_d = GRANT_NONE;
        slave_sel_d = SLAVE_NONE;
        m1_grant_d  = 1'b0;
        m2_grant_d  = 1'b0;
        bus_busy_d  = (state_d != ST_IDLE);
        case (state_d)
            ST_GNT_M1: begin
                bus_grant_d = GRANT_M1;
                m1_grant_d  = 1'b1;
                slave_sel_d = (state_q == ST_GNT_M1) ? slave_sel_q : m1_slave_id;
            end
            ST_GNT_M2: begin
                bus_grant_d = GRANT_M2;
                m2_grant_d  = 1'b1;
                slave_sel_d = (state_q == ST_GNT_M2) ? slave_sel_q : m2_slave_id;
            end
            default: begin
                bus_grant_d = GRANT_NONE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any tenure without a timeout pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= GRANT_M2;
            m1_lock_q    <= 1'b0;
            m2_lock_q    <= 1'b0;
            bus_grant_q  <= GRANT_NONE;
            slave_sel_q  <= SLAVE_NONE;
            m1_grant_q   <= 1'b0;
            m2_grant_q   <= 1'b0;
            m1_timeout_q <= 1'b0;
            m2_timeout_q <= 1'b0;
            bus_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            m1_lock_q    <= m1_lock_d;
            m2_lock_q    <= m2_lock_d;
            bus_grant_q  <= bus_grant_d;
            slave_sel_q  <= slave_sel_d;
            m1_grant_q   <= m1_grant_d;
            m2_grant_q   <= m2_grant_d;
            m1_timeout_q <= m1_timeout_d;
            m2_timeout_q <= m2_timeout_d;
            bus_busy_q   <= bus_busy_d;
        end
    end

    assign bus_grant  = bus_grant_q;
    assign slave_sel  = slave_sel_q;
    assign m1_grant   = m1_grant_q;
    assign m2_grant   = m2_grant_q;
    assign m1_timeout = m1_timeout_q;
    assign m2_timeout = m2_timeout_q;
    assign bus_busy   = bus_busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus randomized traffic checked
// against a tenure-level reference model.
module tb_bus_arbiter;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m1_request = 1'b0;
    logic [1:0] m1_slave_id = 2'd0;
    logic       m2_request = 1'b0;
    logic [1:0] m2_slave_id = 2'd0;
    logic [1:0] bus_grant;
    logic [1:0] slave_sel;
    logic       m1_grant;
    logic       m2_grant;
    logic       m1_timeout;
    logic       m2_timeout;
    logic       bus_busy;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m1_request  (m1_request),
        .m1_slave_id (m1_slave_id),
        .m2_request  (m2_request),
        .m2_slave_id (m2_slave_id),
        .bus_grant   (bus_grant),
        .slave_sel   (slave_sel),
        .m1_grant    (m1_grant),
        .m2_grant    (m2_grant),
        .m1_timeout  (m1_timeout),
        .m2_timeout  (m2_timeout),
        .bus_busy    (bus_busy)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    logic [8:0] dut_vec;
    assign dut_vec = {bus_grant, slave_sel, m1_grant, m2_grant, m1_timeout, m2_timeout, bus_busy};

    // Reference model: who owns the bus, how long they have held it,
    // whether the bus is in its post-tenure gap, and who is locked out.
    logic [1:0] mdl_owner = 2'd0;
    logic [1:0] mdl_last  = 2'd2;
    logic [1:0] mdl_sel   = 2'd0;
    logic       mdl_turn  = 1'b0;
    int         mdl_held  = 0;
    logic       mdl_lock  [4] = '{default: 1'b0};
    logic       mdl_pulse [4] = '{default: 1'b0};

    // Advance the reference model on every rising edge from the sampled inputs
    always @(posedge clk) begin : reference_model
        logic       rq   [4];
        logic [1:0] sid  [4];
        logic       elig [4];
        logic       nlk  [4];
        logic [1:0] winner;
        rq[0] = 1'b0; rq[1] = m1_request; rq[2] = m2_request; rq[3] = 1'b0;
        sid[0] = 2'd0; sid[1] = m1_slave_id; sid[2] = m2_slave_id; sid[3] = 2'd0;
        for (int m = 0; m < 4; m++) mdl_pulse[m] = 1'b0;
        if (!rst) begin
            mdl_owner = 2'd0;
            mdl_last  = 2'd2;
            mdl_sel   = 2'd0;
            mdl_turn  = 1'b0;
            mdl_held  = 0;
            for (int m = 0; m < 4; m++) mdl_lock[m] = 1'b0;
        end else begin
            for (int m = 0; m < 4; m++) begin
                nlk[m]  = mdl_lock[m] && rq[m];
                elig[m] = rq[m] && (sid[m] != 2'd0) && !mdl_lock[m];
            end
            if (mdl_owner != 2'd0) begin
                if (!rq[mdl_owner]) begin
                    mdl_owner = 2'd0;
                    mdl_turn  = 1'b1;
                    mdl_sel   = 2'd0;
                end else if (mdl_held == TIMEOUT - 1) begin
                    mdl_pulse[mdl_owner] = 1'b1;
                    nlk[mdl_owner]       = 1'b1;
                    mdl_owner = 2'd0;
                    mdl_turn  = 1'b1;
                    mdl_sel   = 2'd0;
                end else begin
                    mdl_held = mdl_held + 1;
                end
            end else if (mdl_turn) begin
                mdl_turn = 1'b0;
            end else begin
                if (elig[1] && elig[2]) winner = (mdl_last == 2'd1) ? 2'd2 : 2'd1;
                else if (elig[1])       winner = 2'd1;
                else if (elig[2])       winner = 2'd2;
                else                    winner = 2'd0;
                if (winner != 2'd0) begin
                    mdl_owner = winner;
                    mdl_last  = winner;
                    mdl_held  = 0;
                    mdl_sel   = sid[winner];
                end
            end
            for (int m = 0; m < 4; m++) mdl_lock[m] = nlk[m];
        end
    end

    function automatic logic [8:0] model_vec();
        return {mdl_owner, mdl_sel, mdl_owner == 2'd1, mdl_owner == 2'd2,
                mdl_pulse[1], mdl_pulse[2], (mdl_owner != 2'd0) || mdl_turn};
    endfunction

    // Wait for the next rising edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return to the reset state with both requests idle
    task automatic reset_dut();
        rst = 1'b0;
        m1_request = 1'b0; m1_slave_id = 2'd0;
        m2_request = 1'b0; m2_slave_id = 2'd0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m1_request = 1'b1; m1_slave_id = 2'd2;
        m2_request = 1'b0; m2_slave_id = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec !== 9'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs_zero: got %b, expected 000000000", dut_vec);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus_grant !== 2'd1 || slave_sel !== 2'd2 || m1_grant !== 1'b1 || m2_grant !== 1'b0 || bus_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got grant=%0d sel=%0d m1g=%b m2g=%b busy=%b, expected 1/2/1/0/1",
                     bus_grant, slave_sel, m1_grant, m2_grant, bus_busy);
        end
        m1_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b0;
        m1_request = 1'b1; m1_slave_id = 2'd1;
        m2_request = 1'b1; m2_slave_id = 2'd3;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus_grant !== 2'd1 || slave_sel !== 2'd1 || m1_grant !== 1'b1 || m2_grant !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_tie_first: got grant=%0d sel=%0d, expected 1/1", bus_grant, slave_sel);
        end
        tick();
        tick();
        m1_request = 1'b0;
        tick();
        checks++;
        if (bus_grant !== 2'd0 || slave_sel !== 2'd0 || m1_grant !== 1'b0 || m2_grant !== 1'b0 || bus_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_turnaround: got grant=%0d sel=%0d busy=%b, expected 0/0/1", bus_grant, slave_sel, bus_busy);
        end
        tick();
        checks++;
        if (bus_grant !== 2'd0 || bus_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_idle_gap: got grant=%0d busy=%b, expected 0/0", bus_grant, bus_busy);
        end
        tick();
        checks++;
        if (bus_grant !== 2'd2 || slave_sel !== 2'd3 || m2_grant !== 1'b1 || m1_grant !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_second_master: got grant=%0d sel=%0d, expected 2/3", bus_grant, slave_sel);
        end
        m2_request = 1'b0;
        tick();
        m1_request = 1'b1; m1_slave_id = 2'd1;
        m2_request = 1'b1; m2_slave_id = 2'd3;
        tick();
        tick();
        checks++;
        if (bus_grant !== 2'd1 || slave_sel !== 2'd1) begin
            errors++;
            $display("[TB] FAIL rr_alternate_back: got grant=%0d sel=%0d, expected 1/1", bus_grant, slave_sel);
        end
        m1_request = 1'b0; m2_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_invalid_slave_id();
        int bad;
        reset_dut();
        m1_request = 1'b1; m1_slave_id = 2'd0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_grant !== 2'd0 || bus_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL invalid_id_ignored: got %0d granted/busy cycles, expected 0", bad);
        end
        m1_slave_id = 2'd3;
        tick();
        checks++;
        if (bus_grant !== 2'd1 || slave_sel !== 2'd3 || m1_grant !== 1'b1) begin
            errors++;
            $display("[TB] FAIL valid_id_granted: got grant=%0d sel=%0d, expected 1/3", bus_grant, slave_sel);
        end
        m1_slave_id = 2'd1;
        tick();
        checks++;
        if (bus_grant !== 2'd1 || slave_sel !== 2'd3) begin
            errors++;
            $display("[TB] FAIL slave_sel_frozen: got grant=%0d sel=%0d, expected 1/3", bus_grant, slave_sel);
        end
        m1_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int pulses;
        int regrants;
        reset_dut();
        m1_request = 1'b1; m1_slave_id = 2'd2;
        pulses = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            if (m1_timeout === 1'b1) pulses++;
            checks++;
            if (bus_grant !== 2'd1 || m1_timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_tenure_cycle%0d: got grant=%0d to=%b, expected 1/0", i, bus_grant, m1_timeout);
            end
        end
        tick();
        if (m1_timeout === 1'b1) pulses++;
        checks++;
        if (m1_timeout !== 1'b1 || bus_grant !== 2'd0 || bus_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: got to=%b grant=%0d busy=%b, expected 1/0/1", m1_timeout, bus_grant, bus_busy);
        end
        regrants = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m1_timeout === 1'b1) pulses++;
            if (bus_grant !== 2'd0) regrants++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulse_count: got %0d, expected 1", pulses);
        end
        checks++;
        if (regrants != 0) begin
            errors++;
            $display("[TB] FAIL timeout_lockout: got %0d granted cycles, expected 0", regrants);
        end
        m1_request = 1'b0;
        tick();
        m1_request = 1'b1;
        tick();
        checks++;
        if (bus_grant !== 2'd1 || slave_sel !== 2'd2) begin
            errors++;
            $display("[TB] FAIL timeout_unlock_regrant: got grant=%0d sel=%0d, expected 1/2", bus_grant, slave_sel);
        end
        m1_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout_with_waiter();
        reset_dut();
        m1_request = 1'b1; m1_slave_id = 2'd1;
        tick();
        m2_request = 1'b1; m2_slave_id = 2'd2;
        for (int i = 1; i < TIMEOUT; i++) tick();
        tick();
        checks++;
        if (m1_timeout !== 1'b1 || bus_grant !== 2'd0) begin
            errors++;
            $display("[TB] FAIL waiter_timeout_pulse: got to=%b grant=%0d, expected 1/0", m1_timeout, bus_grant);
        end
        tick();
        tick();
        checks++;
        if (bus_grant !== 2'd2 || slave_sel !== 2'd2 || m2_grant !== 1'b1) begin
            errors++;
            $display("[TB] FAIL waiter_granted: got grant=%0d sel=%0d, expected 2/2", bus_grant, slave_sel);
        end
        m1_request = 1'b0; m2_request = 1'b0;
        tick();
        tick();

        reset_dut();
        m1_request = 1'b1; m1_slave_id = 2'd3;
        for (int i = 0; i < TIMEOUT; i++) tick();
        m1_request = 1'b0;
        tick();
        checks++;
        if (m1_timeout !== 1'b0 || bus_grant !== 2'd0 || bus_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_beats_timeout: got to=%b grant=%0d busy=%b, expected 0/0/1", m1_timeout, bus_grant, bus_busy);
        end
        m1_request = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_grant !== 2'd1 || slave_sel !== 2'd3) begin
            errors++;
            $display("[TB] FAIL release_no_lock: got grant=%0d sel=%0d, expected 1/3", bus_grant, slave_sel);
        end
        m1_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_tenure();
        reset_dut();
        m2_request = 1'b1; m2_slave_id = 2'd3;
        tick();
        tick();
        tick();
        checks++;
        if (m2_grant !== 1'b1 || bus_grant !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mid_tenure_setup: got m2g=%b grant=%0d, expected 1/2", m2_grant, bus_grant);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dut_vec !== 9'd0) begin
            errors++;
            $display("[TB] FAIL mid_tenure_reset: got %b, expected 000000000", dut_vec);
        end
        rst = 1'b1;
        m1_request = 1'b1; m1_slave_id = 2'd1;
        m2_slave_id = 2'd2;
        tick();
        checks++;
        if (bus_grant !== 2'd1 || slave_sel !== 2'd1 || m2_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_tie: got grant=%0d sel=%0d m2to=%b, expected 1/1/0", bus_grant, slave_sel, m2_timeout);
        end
        m1_request = 1'b0; m2_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        reset_dut();
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst = ($urandom_range(99, 0) < 2) ? 1'b0 : 1'b1;
            if (m1_request) begin
                if ($urandom_range(99, 0) < 12) m1_request = 1'b0;
                if ($urandom_range(99, 0) < 8)  m1_slave_id = 2'($urandom_range(3, 0));
            end else if ($urandom_range(99, 0) < 35) begin
                m1_request  = 1'b1;
                m1_slave_id = 2'($urandom_range(3, 0));
            end
            if (m2_request) begin
                if ($urandom_range(99, 0) < 12) m2_request = 1'b0;
                if ($urandom_range(99, 0) < 8)  m2_slave_id = 2'($urandom_range(3, 0));
            end else if ($urandom_range(99, 0) < 35) begin
                m2_request  = 1'b1;
                m2_slave_id = 2'($urandom_range(3, 0));
            end
            tick();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got {grant,sel,g1,g2,to1,to2,busy}=%b, expected %b",
                         cyc, dut_vec, model_vec());
            end
            checks++;
            if (m1_grant === 1'b1 && m2_grant === 1'b1) begin
                errors++;
                $display("[TB] FAIL random_exclusive%0d: got m1g=1 m2g=1, expected at most one", cyc);
            end
        end
        rst = 1'b1;
        m1_request = 1'b0; m2_request = 1'b0;
        tick();
        tick();
    endtask

    // Run every scenario in turn, then report
    initial begin
        $display("[TB] bus_arbiter bench start, TIMEOUT=%0d", TIMEOUT);
        test_reset();
        test_round_robin();
        test_invalid_slave_id();
        test_timeout();
        test_timeout_with_waiter();
        test_reset_mid_tenure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
